// File: rtl/free_list.sv
// Circular FIFO of free physical register tags feeding the rename map table.
// Optional macro FREE_LIST_OVERFLOW_CHECK_EN drops illegal enqueues and raises a sticky overflow_err.
module free_list #(
  parameter int N_WAY     = 2,
  parameter int PRF_SIZE  = 64,
  parameter int ARCH_REGS = 32,
  parameter int PR_BITS   = 6
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [N_WAY-1:0]              alloc_req,
  output logic [N_WAY-1:0][PR_BITS-1:0] pr_freelist,
  output logic                          alloc_stall,
  input  logic [N_WAY-1:0]              retire_valid,
  input  logic [N_WAY-1:0][PR_BITS-1:0] retire_told,
  input  logic                          branch_haz,
  output logic [PR_BITS-1:0]            free_count,
  output logic                          overflow_err
);

  localparam int FREE_TOTAL = PRF_SIZE - 1 - ARCH_REGS;
  localparam int IDX_W      = $clog2(FREE_TOTAL);

  logic [PR_BITS-1:0] slot_q [FREE_TOTAL];
  logic [PR_BITS-1:0] slot_d [FREE_TOTAL];
  logic [IDX_W-1:0]   head_q, head_d;
  logic [IDX_W-1:0]   tail_q, tail_d;
  logic [PR_BITS-1:0] count_q, count_d;
  int unsigned        cnt, nreq, ngrant, nenq;

`ifdef FREE_LIST_OVERFLOW_CHECK_EN
  logic               drop;
  logic               overflow_q, overflow_d;
`endif

  // Offsets never exceed N_WAY, so a single conditional subtract is enough.
  function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] idx,
                                                input int unsigned off);
    int unsigned s;
    s = 32'(idx) + off;
    if (s >= 32'(FREE_TOTAL)) s = s - 32'(FREE_TOTAL);
    return s[IDX_W-1:0];
  endfunction

  // Allocation: requesting ways take consecutive slots from head in way order.
  always_comb begin
    cnt         = 32'(count_q);
    nreq        = 0;
    pr_freelist = '0;
    for (int w = 0; w < N_WAY; w++) begin
      if (alloc_req[w]) begin
        if (nreq < cnt) pr_freelist[w] = slot_q[wrap_add(head_q, nreq)];
        nreq = nreq + 1;
      end
    end
    alloc_stall = (nreq > cnt);
    if (branch_haz) ngrant = 0;
    else            ngrant = (nreq < cnt) ? nreq : cnt;
  end

  // Reclaim: non-null T_old tags are appended at tail; recovery then snaps head to the new tail.
  always_comb begin
    slot_d = slot_q;
    nenq   = 0;
`ifdef FREE_LIST_OVERFLOW_CHECK_EN
    drop   = 1'b0;
`endif
    for (int w = 0; w < N_WAY; w++) begin
      if (retire_valid[w] && (retire_told[w] > PR_BITS'(1))) begin
`ifdef FREE_LIST_OVERFLOW_CHECK_EN
        if ((32'(retire_told[w]) >= 32'(PRF_SIZE)) ||
            (cnt - ngrant + nenq >= 32'(FREE_TOTAL))) begin
          drop = 1'b1;
        end else begin
          slot_d[wrap_add(tail_q, nenq)] = retire_told[w];
          nenq = nenq + 1;
        end
`else
        slot_d[wrap_add(tail_q, nenq)] = retire_told[w];
        nenq = nenq + 1;
`endif
      end
    end
    tail_d = wrap_add(tail_q, nenq);
    if (branch_haz) begin
      head_d  = tail_d;
      count_d = PR_BITS'(FREE_TOTAL);
    end else begin
      head_d  = wrap_add(head_q, ngrant);
      count_d = PR_BITS'(cnt + nenq - ngrant);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= PR_BITS'(FREE_TOTAL);
      for (int i = 0; i < FREE_TOTAL; i++) slot_q[i] <= PR_BITS'(ARCH_REGS + 1 + i);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      slot_q  <= slot_d;
    end
  end

  assign free_count = count_q;

`ifdef FREE_LIST_OVERFLOW_CHECK_EN
  always_comb begin
    overflow_d = overflow_q | drop;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      if (drop) $error("free_list: enqueue dropped (overflow or out-of-range tag)");
    end
  end

  assign overflow_err = overflow_q;
`else
  assign overflow_err = 1'b0;
`endif

endmodule

// File: tb/tb_free_list.sv
// Scoreboard bench for free_list: expected grants are queued when stimulus is driven and popped at the sample point.
module tb_free_list;

  logic            clock = 1'b0;
  logic            reset;
  logic [1:0]      alloc_req;
  logic [1:0][5:0] pr_freelist;
  logic            alloc_stall;
  logic [1:0]      retire_valid;
  logic [1:0][5:0] retire_told;
  logic            branch_haz;
  logic [5:0]      free_count;
  logic            overflow_err;

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  int model_q[$];

  always #5 clock = ~clock;

  free_list dut (
    .clock        (clock),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .pr_freelist  (pr_freelist),
    .alloc_stall  (alloc_stall),
    .retire_valid (retire_valid),
    .retire_told  (retire_told),
    .branch_haz   (branch_haz),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  // Apply inputs, then wait for the falling edge where outputs are sampled.
  task automatic drive(input logic [1:0] req, input logic [1:0] rv,
                       input logic [5:0] t0, input logic [5:0] t1, input logic bh);
    alloc_req      = req;
    retire_valid   = rv;
    retire_told[0] = t0;
    retire_told[1] = t1;
    branch_haz     = bh;
    @(negedge clock);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    int e;
    do_reset();
    exp_q.push_back(0); exp_q.push_back(0);
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL reset_pr way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (alloc_stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", alloc_stall); end
    total++; if (free_count !== 6'd31) begin bad++; $display("FAIL reset_count: got %0d want 31", free_count); end
    total++; if (overflow_err !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    step();
  endtask

  task automatic test_alloc_pair();
    int e;
    do_reset();
    exp_q.push_back(33); exp_q.push_back(34);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL pair1 way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (alloc_stall !== 1'b0) begin bad++; $display("FAIL pair1_stall: got %b want 0", alloc_stall); end
    step();
    exp_q.push_back(35); exp_q.push_back(36);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd29) begin bad++; $display("FAIL pair_count: got %0d want 29", free_count); end
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL pair2 way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd27) begin bad++; $display("FAIL pair_count2: got %0d want 27", free_count); end
    step();
  endtask

  task automatic test_partial();
    int e;
    do_reset();
    exp_q.push_back(0); exp_q.push_back(33);
    drive(2'b10, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL partial way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (alloc_stall !== 1'b0) begin bad++; $display("FAIL partial_stall: got %b want 0", alloc_stall); end
    total++; if (free_count !== 6'd31) begin bad++; $display("FAIL partial_count0: got %0d want 31", free_count); end
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd30) begin bad++; $display("FAIL partial_count1: got %0d want 30", free_count); end
    step();
  endtask

  task automatic test_empty();
    int e;
    do_reset();
    repeat (15) begin
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      step();
    end
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd1) begin bad++; $display("FAIL drain_count: got %0d want 1", free_count); end
    step();
    exp_q.push_back(63); exp_q.push_back(0);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL last_tag way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (alloc_stall !== 1'b1) begin bad++; $display("FAIL last_stall: got %b want 1", alloc_stall); end
    step();
    exp_q.push_back(0); exp_q.push_back(0);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL empty way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (alloc_stall !== 1'b1) begin bad++; $display("FAIL empty_stall: got %b want 1", alloc_stall); end
    total++; if (free_count !== 6'd0) begin bad++; $display("FAIL empty_count: got %0d want 0", free_count); end
    step();
  endtask

  // Runs from the empty state left by test_empty.
  task automatic test_null_retire();
    int e;
    drive(2'b00, 2'b11, 6'd0, 6'd5, 1'b0);
    total++; if (free_count !== 6'd0) begin bad++; $display("FAIL null_count0: got %0d want 0", free_count); end
    step();
    exp_q.push_back(5); exp_q.push_back(0);
    drive(2'b01, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd1) begin bad++; $display("FAIL null_count1: got %0d want 1", free_count); end
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL null_grant way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    step();
  endtask

  // Steady alloc-2/retire-2 traffic; head and tail both straddle slot 30->0.
  task automatic test_wrap();
    int e;
    logic [5:0] t;
    model_q.delete();
    drive(2'b00, 2'b11, 6'd40, 6'd41, 1'b0);
    model_q.push_back(40); model_q.push_back(41);
    step();
    exp_q.push_back(model_q.pop_front()); exp_q.push_back(0);
    drive(2'b01, 2'b10, 6'd0, 6'd42, 1'b0);
    model_q.push_back(42);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL wrap_pre way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    step();
    for (int k = 0; k < 18; k++) begin
      t = 6'(10 + 2 * k);
      exp_q.push_back(model_q.pop_front()); exp_q.push_back(model_q.pop_front());
      drive(2'b11, 2'b11, t, t + 6'd1, 1'b0);
      model_q.push_back(int'(t)); model_q.push_back(int'(t) + 1);
      for (int w = 0; w < 2; w++) begin
        e = exp_q.pop_front(); total++;
        if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL wrap k%0d way%0d: got %0d want %0d", k, w, pr_freelist[w], e); end
      end
      total++; if (alloc_stall !== 1'b0) begin bad++; $display("FAIL wrap_stall k%0d: got %b want 0", k, alloc_stall); end
      total++; if (free_count !== 6'd2) begin bad++; $display("FAIL wrap_count k%0d: got %0d want 2", k, free_count); end
      step();
    end
  endtask

  task automatic test_branch();
    int e;
    do_reset();
    exp_q.push_back(33); exp_q.push_back(34);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL br_pre1 way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    step();
    exp_q.push_back(35); exp_q.push_back(36);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL br_pre2 way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    step();
    exp_q.push_back(37); exp_q.push_back(38);
    drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b1);
    for (int w = 0; w < 2; w++) begin
      e = exp_q.pop_front(); total++;
      if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL br_drive way%0d: got %0d want %0d", w, pr_freelist[w], e); end
    end
    total++; if (free_count !== 6'd27) begin bad++; $display("FAIL br_count0: got %0d want 27", free_count); end
    step();
    drive(2'b00, 2'b00, 6'd0, 6'd0, 1'b0);
    total++; if (free_count !== 6'd31) begin bad++; $display("FAIL br_count1: got %0d want 31", free_count); end
    step();
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(33 + 2 * k); exp_q.push_back(34 + 2 * k);
      drive(2'b11, 2'b00, 6'd0, 6'd0, 1'b0);
      for (int w = 0; w < 2; w++) begin
        e = exp_q.pop_front(); total++;
        if (pr_freelist[w] !== 6'(e)) begin bad++; $display("FAIL br_post%0d way%0d: got %0d want %0d", k, w, pr_freelist[w], e); end
      end
      step();
    end
  endtask

  initial begin
    reset        = 1'b1;
    alloc_req    = '0;
    retire_valid = '0;
    retire_told  = '0;
    branch_haz   = 1'b0;
    test_reset();
    test_alloc_pair();
    test_partial();
    test_empty();
    test_null_retire();
    test_wrap();
    test_branch();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular FIFO of free physical register tags for the N-way rename stage.
- Sits directly upstream of the map table: it supplies the per-way new physical register, driving the map table's pr_freelist input.
- Reclaims T_old tags (the physical register a retiring instruction's destination previously mapped to) from the ROB at retire.
- Restores itself to "all non-architectural PRs free" on a retire-time branch recovery.

Parameters:
- N_WAY, 2, superscalar width (dispatch and retire ways).
- PRF_SIZE, 64, number of physical registers. PR 0 is the null tag and is never allocated.
- ARCH_REGS, 32, architectural registers. PRs 1..ARCH_REGS hold the reset architectural mapping.
- PR_BITS, 6, physical tag width (CDB_BITS); must satisfy 2^PR_BITS >= PRF_SIZE.
- FREE_TOTAL (derived), PRF_SIZE-1-ARCH_REGS = 31, FIFO depth and capacity.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- alloc_req  in  N_WAY  per dispatch way: valid instruction with dest != x0.
- pr_freelist  out  N_WAY x PR_BITS  allocated tag per way; 0 means no allocation.
- alloc_stall  out  1  more requests than free entries this cycle.
- retire_valid  in  N_WAY  per retire way: instruction retiring.
- retire_told  in  N_WAY x PR_BITS  T_old of the retiring instruction.
- branch_haz  in  1  retire-time mispredict recovery.
- free_count  out  PR_BITS  current number of free entries (registered).
- overflow_err  out  1  see Optional Feature.

Behaviour:
- State: slot array [FREE_TOTAL], head, tail (each modulo FREE_TOTAL), count.
- Reset:
  - slot[i] = ARCH_REGS+1+i, giving tags 33..63.
  - head = 0, tail = 0, count = FREE_TOTAL.
  - overflow_err = 0.
  - Outputs follow the state combinationally; with alloc_req = 0, pr_freelist is all 0 and alloc_stall = 0.
- Allocation (combinational from registered state, zero latency):
  - rank(w) = number of set alloc_req bits in ways below w.
  - If alloc_req[w] and rank(w) < count: pr_freelist[w] = slot[(head+rank(w)) mod FREE_TOTAL].
  - Otherwise pr_freelist[w] = 0.
  - Granted ways always form a prefix of the requesting ways.
  - alloc_stall = popcount(alloc_req) > count.
- Dequeue: at the clock edge, head advances by ngrant = min(popcount(alloc_req), count).
- Enqueue:
  - Retire way w enqueues when retire_valid[w] is set and retire_told[w] is neither 0 nor 1 (PR 1 is the permanent x0 mapping).
  - Enqueued tags are written at tail, tail+1, ... in way order; tail advances by nenq.
- Count: count_next = count + nenq - ngrant.
  - Tags enqueued in a cycle are not visible to allocation until the next cycle; there is no bypass.
- Empty: count = 0 gives all pr_freelist = 0, and alloc_stall = 1 if any request is present.
- Full: count = FREE_TOTAL. Enqueue at full is illegal under correct ROB operation.
- Wrap-around: all slot indices are taken modulo FREE_TOTAL; this must work for any head/tail pair, including a multi-way access that straddles the wrap.
- branch_haz:
  - Retire enqueues of the same cycle are performed first.
  - Then head <= tail_next and count <= FREE_TOTAL.
  - alloc_req is ignored that cycle: ngrant = 0, but pr_freelist is still driven.
  - Recovery is correct because depth = FREE_TOTAL: the squashed in-flight tags occupy exactly the vacated slots tail..head-1.
- reset overrides branch_haz and all traffic in the same cycle.

Optional Feature:
- Macro: FREE_LIST_OVERFLOW_CHECK_EN.
- Defined:
  - Any enqueue that would make count exceed FREE_TOTAL, or any retire_told >= PRF_SIZE, is dropped.
  - Such an event sets overflow_err, which is sticky until reset.
  - A simulation $error is issued.
- Undefined:
  - No check is performed and enqueues are unconditional.
  - overflow_err is tied 0.

Test Plan:
- Reset, then alloc_req=2'b11 -> pr_freelist={34,33} (way1, way0); next cycle free_count=29; repeat -> {36,35}.
- alloc_req=2'b10 -> pr_freelist[0]=0, pr_freelist[1]=33, alloc_stall=0, free_count goes 31->30.
- Drain to count=1, alloc_req=2'b11 -> way0 gets the last tag, way1=0, alloc_stall=1, free_count=0; any request at count 0 -> all 0, stall=1.
- At count=0, retire told {0,5} valid on both ways -> only tag 5 enqueued, count=1; next cycle alloc_req=2'b01 -> pr_freelist[0]=5.
- Allocate 2 and retire 2 non-null tags in the same cycle -> free_count unchanged; tags retired that cycle are not granted until the next cycle; exercise the path across the head/tail wrap at index 30->0.
- From reset, allocate 4 tags (33..36) with no retires, then branch_haz=1 with alloc_req=2'b11 -> free_count=31 next cycle and head unchanged by the request; following allocations return 33,34,35,36 in order.
